ni_flit_injector: RTL

//  Endpoint-side transmitter for one NoC local port: turns packet requests plus payload words into

---
 rtl/pronoc_pkg.sv | 37 +++
 rtl/ni_credit_counter.sv | 45 ++++
 rtl/ni_flit_injector.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pronoc_pkg.sv
// Shared constants and types for the NoC endpoint flit injector.
//   V     : virtual channels per port
//   B     : downstream buffer depth per VC (initial credit count)
//   Fpay  : flit payload width, Fw = 2 + V + Fpay
//   DSTw  : destination address width
//   LENw  : packet length field width
// Flit layout: {head, tail, vc_onehot[V], payload[Fpay]}
// Head payload layout: {dest[DSTw], len[LENw], zero pad}
package pronoc_pkg;

  localparam int V       = 4;
  localparam int B       = 4;
  localparam int Fpay    = 32;
  localparam int Fw      = 2 + V + Fpay;
  localparam int DSTw    = 8;
  localparam int LENw    = 5;
  localparam int VCw     = $clog2(V);
  localparam int CNTw    = $clog2(B + 1);

  localparam int HEAD_BIT = Fw - 1;
  localparam int TAIL_BIT = Fw - 2;
  localparam int VC_LSB   = Fpay;
  localparam int HDR_PAD  = Fpay - DSTw - LENw;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } ni_state_t;

  function automatic logic [V-1:0] vc_onehot(input logic [VCw-1:0] vc);
    logic [V-1:0] one;
    one = {{(V-1){1'b0}}, 1'b1};
    return one << vc;
  endfunction

endpackage

// File: rtl/ni_credit_counter.sv
// Per-VC downstream credit counter.
// Starts at B after reset; dec_i on a flit send, inc_i on a returned credit,
// both together leave the count unchanged.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   inc_i          : credit returned by the router this cycle
//   dec_i          : flit sent on this VC this cycle
//   has_credit_o   : at least one free downstream slot
//   count_o        : current credit count
module ni_credit_counter #(
  parameter int B = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inc_i,
  input  logic                   dec_i,
  output logic                   has_credit_o,
  output logic [$clog2(B+1)-1:0] count_o
);

  localparam int CW = $clog2(B + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= CW'(B);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign has_credit_o = (cnt_q != '0);
  assign count_o      = cnt_q;

endmodule

// File: rtl/ni_flit_injector.sv
// Endpoint-side NoC transmitter: converts packet requests plus payload words
// into head/body/tail flits, sending only when the packet's VC has credit.
// Optional feature macro: NI_STATS_EN (packet / stall statistics counters).
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   flit_out, flit_out_wr : registered flit and its one-cycle valid
//   credit_in             : per-VC credit return pulses
//   pck_*                 : packet request (dest, vc, len) with valid/ready
//   dat_*                 : payload words for body/tail flits with valid/ready
//   stat_pck, stat_stall  : packets sent / cycles stalled on zero credit
module ni_flit_injector
  import pronoc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  output logic [Fw-1:0]   flit_out,
  output logic            flit_out_wr,
  input  logic [V-1:0]    credit_in,
  input  logic            pck_valid,
  output logic            pck_ready,
  input  logic [DSTw-1:0] pck_dest,
  input  logic [VCw-1:0]  pck_vc,
  input  logic [LENw-1:0] pck_len,
  input  logic            dat_valid,
  output logic            dat_ready,
  input  logic [Fpay-1:0] dat,
  output logic [31:0]     stat_pck,
  output logic [31:0]     stat_stall
);

  ni_state_t            state_q, state_d;
  logic [DSTw-1:0]      dest_q, dest_d;
  logic [VCw-1:0]       vc_q, vc_d;
  logic [LENw-1:0]      len_q, len_d;
  logic [LENw-1:0]      rem_q, rem_d;
  logic [Fw-1:0]        flit_q, flit_d;
  logic                 flit_wr_q;
  logic                 ready_q;
  logic                 send, tail_send, cur_credit;
  logic [V-1:0]         has_credit, dec_vec;
  logic [V-1:0][CNTw-1:0] credit_cnt;

  for (genvar v = 0; v < V; v++) begin : g_cred
    ni_credit_counter #(.B(B)) u_cnt (
      .clk          (clk),
      .reset        (reset),
      .inc_i        (credit_in[v]),
      .dec_i        (dec_vec[v]),
      .has_credit_o (has_credit[v]),
      .count_o      (credit_cnt[v])
    );

    always_ff @(posedge clk) begin
      if (reset) begin
        assert (!(credit_in[v] && !dec_vec[v] && credit_cnt[v] == CNTw'(B)))
          else $error("credit overflow on VC %0d", v);
        assert (!(dec_vec[v] && !credit_in[v] && credit_cnt[v] == '0))
          else $error("credit underflow on VC %0d", v);
      end
    end
  end

  assign cur_credit = has_credit[vc_q];
  assign dec_vec    = send ? vc_onehot(vc_q) : '0;

  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    vc_d      = vc_q;
    len_d     = len_q;
    rem_d     = rem_q;
    flit_d    = flit_q;
    send      = 1'b0;
    tail_send = 1'b0;
    pck_ready = 1'b0;
    dat_ready = 1'b0;
    case (state_q)
      IDLE: begin
        // ready_q keeps the request port closed until the first clock after reset
        pck_ready = ready_q;
        if (pck_valid && ready_q) begin
          dest_d  = pck_dest;
          vc_d    = pck_vc;
          len_d   = (pck_len == '0) ? LENw'(1) : pck_len;
          rem_d   = len_d - 1'b1;
          state_d = HEAD;
        end
      end
      HEAD: begin
        if (cur_credit) begin
          send      = 1'b1;
          tail_send = (len_q <= LENw'(1));
          flit_d    = {1'b1, tail_send, vc_onehot(vc_q), dest_q, len_q, {HDR_PAD{1'b0}}};
          state_d   = (rem_q != '0) ? BODY : IDLE;
        end
      end
      BODY: begin
        dat_ready = cur_credit;
        if (dat_valid && cur_credit) begin
          send      = 1'b1;
          tail_send = (rem_q == LENw'(1));
          flit_d    = {1'b0, tail_send, vc_onehot(vc_q), dat};
          rem_d     = rem_q - 1'b1;
          if (tail_send) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      dest_q    <= '0;
      vc_q      <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      flit_q    <= '0;
      flit_wr_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      vc_q      <= vc_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      flit_q    <= flit_d;
      flit_wr_q <= send;
      ready_q   <= 1'b1;
    end
  end

  assign flit_out    = flit_q;
  assign flit_out_wr = flit_wr_q;

`ifdef NI_STATS_EN
  logic [31:0] stat_pck_q, stat_stall_q;
  logic        stall;

  // a BODY cycle only counts as stalled when a payload word is actually waiting
  assign stall = !cur_credit && ((state_q == HEAD) || (state_q == BODY && dat_valid));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_pck_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      if (tail_send) stat_pck_q   <= stat_pck_q + 1'b1;
      if (stall)     stat_stall_q <= stat_stall_q + 1'b1;
    end
  end

  assign stat_pck   = stat_pck_q;
  assign stat_stall = stat_stall_q;
`else
  assign stat_pck   = '0;
  assign stat_stall = '0;
`endif

endmodule
